// File: rtl/sprite_layer_mixer.sv
// Sprite layer compositor for the VGA path: fixed-priority layer select, background fill and a
// death-flash / game-over overlay FSM, in a 2-cycle pipeline. Optional macro: COLOR_KEY_EN.
module sprite_layer_mixer #(
    parameter int                 NUM_LAYERS   = 12,
    parameter int                 COLOR_W      = 12,
    parameter logic [COLOR_W-1:0] BG_COLOR     = 12'h69C,
    parameter logic [COLOR_W-1:0] FLASH_COLOR  = 12'h0F0,
    parameter int                 FLASH_FRAMES = 60,
    parameter int                 FLASH_TOGGLE = 8,
    parameter logic [COLOR_W-1:0] KEY_COLOR    = 12'h000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_LAYERS-1:0]         layer_en,
    input  logic [NUM_LAYERS*COLOR_W-1:0] layer_rgb,
    input  logic                          bright,
    input  logic [1:0]                    sync_in,
    input  logic                          frame_tick,
    input  logic                          death,
    input  logic                          game_over,
    output logic [COLOR_W-1:0]            rgb_out,
    output logic [1:0]                    sync_out,
    output logic [1:0]                    mix_state
);

    localparam int FCNT_W = $clog2(FLASH_FRAMES) + 1;
    localparam int TCNT_W = $clog2(FLASH_TOGGLE) + 1;
    localparam logic [FCNT_W-1:0] FRAME_LAST = FCNT_W'(FLASH_FRAMES - 1);
    localparam logic [TCNT_W-1:0] TOG_LAST   = TCNT_W'(FLASH_TOGGLE - 1);

    typedef enum logic [1:0] {
        ST_PLAY  = 2'd0,
        ST_FLASH = 2'd1,
        ST_OVER  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [FCNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [TCNT_W-1:0]   tog_cnt_q, tog_cnt_d;
    logic                phase_q, phase_d;

    logic [NUM_LAYERS-1:0] active;
    logic [COLOR_W-1:0]    sel_rgb_q, sel_rgb_d;
    logic                  hit_q, hit_d;
    logic                  bright_d1_q;
    logic [1:0]            sync_d1_q;
    logic                  overlay_d1_q, overlay_d;
    logic [COLOR_W-1:0]    rgb_out_q, rgb_out_d;
    logic [1:0]            sync_out_q;

`ifdef COLOR_KEY_EN
    // A keyed pixel is transparent and lets lower-priority layers show through.
    always_comb begin
        for (int i = 0; i < NUM_LAYERS; i++) begin
            active[i] = layer_en[i] && (layer_rgb[i*COLOR_W +: COLOR_W] != KEY_COLOR);
        end
    end
`else
    localparam logic [COLOR_W-1:0] key_color_unused = KEY_COLOR;
    assign active = layer_en;
`endif

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (latch).
    always_comb begin
        sel_rgb_d = '0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (active[i]) begin
                sel_rgb_d = layer_rgb[i*COLOR_W +: COLOR_W];
            end
        end
        hit_d = |active;
    end

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        tog_cnt_d   = tog_cnt_q;
        phase_d     = phase_q;
        case (state_q)
            ST_PLAY: begin
                if (game_over) begin
                    state_d = ST_OVER;
                end else if (death) begin
                    state_d     = ST_FLASH;
                    frame_cnt_d = '0;
                    tog_cnt_d   = '0;
                    phase_d     = 1'b1;
                end
            end
            ST_FLASH: begin
                // A restart outranks a simultaneous frame_tick.
                if (game_over) begin
                    state_d = ST_OVER;
                end else if (death) begin
                    frame_cnt_d = '0;
                    tog_cnt_d   = '0;
                    phase_d     = 1'b1;
                end else if (frame_tick) begin
                    if (frame_cnt_q == FRAME_LAST) begin
                        state_d     = ST_PLAY;
                        frame_cnt_d = '0;
                        tog_cnt_d   = '0;
                        phase_d     = 1'b0;
                    end else begin
                        frame_cnt_d = frame_cnt_q + FCNT_W'(1);
                        if (tog_cnt_q == TOG_LAST) begin
                            tog_cnt_d = '0;
                            phase_d   = ~phase_q;
                        end else begin
                            tog_cnt_d = tog_cnt_q + TCNT_W'(1);
                        end
                    end
                end
            end
            ST_OVER: begin
                state_d = ST_OVER;
            end
            default: begin
                state_d = ST_PLAY;
            end
        endcase
    end

    // Overlay is registered with the pixel so it lands on rgb_out with the same 2-cycle latency.
    assign overlay_d = (state_q == ST_OVER) || ((state_q == ST_FLASH) && phase_q);

    always_comb begin
        rgb_out_d = BG_COLOR;
        if (!bright_d1_q) begin
            rgb_out_d = '0;
        end else if (overlay_d1_q) begin
            rgb_out_d = FLASH_COLOR;
        end else if (hit_q) begin
            rgb_out_d = sel_rgb_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_PLAY;
            frame_cnt_q  <= '0;
            tog_cnt_q    <= '0;
            phase_q      <= 1'b0;
            sel_rgb_q    <= '0;
            hit_q        <= 1'b0;
            bright_d1_q  <= 1'b0;
            sync_d1_q    <= 2'b11;
            overlay_d1_q <= 1'b0;
            rgb_out_q    <= '0;
            sync_out_q   <= 2'b11;
        end else begin
            state_q      <= state_d;
            frame_cnt_q  <= frame_cnt_d;
            tog_cnt_q    <= tog_cnt_d;
            phase_q      <= phase_d;
            sel_rgb_q    <= sel_rgb_d;
            hit_q        <= hit_d;
            bright_d1_q  <= bright;
            sync_d1_q    <= sync_in;
            overlay_d1_q <= overlay_d;
            rgb_out_q    <= rgb_out_d;
            sync_out_q   <= sync_d1_q;
        end
    end

    assign rgb_out   = rgb_out_q;
    assign sync_out  = sync_out_q;
    assign mix_state = state_q;

endmodule

// File: tb/tb_sprite_layer_mixer.sv
// Self-checking bench for sprite_layer_mixer: table-driven pixel vectors plus
// hand-written flash, restart, game-over and reset sequences.
module tb_sprite_layer_mixer;

    localparam int NL = 12;
    localparam int CW = 12;

    logic             clk = 1'b0;
    logic             reset;
    logic [NL-1:0]    layer_en;
    logic [NL*CW-1:0] layer_rgb;
    logic             bright;
    logic [1:0]       sync_in;
    logic             frame_tick;
    logic             death;
    logic             game_over;
    logic [CW-1:0]    rgb_out;
    logic [1:0]       sync_out;
    logic [1:0]       mix_state;

    int n_pass  = 0;
    int n_total = 0;

    sprite_layer_mixer dut (
        .clk        (clk),
        .reset      (reset),
        .layer_en   (layer_en),
        .layer_rgb  (layer_rgb),
        .bright     (bright),
        .sync_in    (sync_in),
        .frame_tick (frame_tick),
        .death      (death),
        .game_over  (game_over),
        .rgb_out    (rgb_out),
        .sync_out   (sync_out),
        .mix_state  (mix_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NL-1:0]    en;
        logic [NL*CW-1:0] rgb;
        logic             bright;
        logic [1:0]       sync;
        logic [CW-1:0]    exp_rgb;
        logic [1:0]       exp_sync;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs[NV];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Layer i gets {i+1, A, i}: layer0=1A0, layer2=3A2, layer8=9A8, layer11=CAB.
    function automatic logic [NL*CW-1:0] palette();
        logic [NL*CW-1:0] p;
        for (int i = 0; i < NL; i++) begin
            p[i*CW +: CW] = {4'(i + 1), 4'hA, 4'(i)};
        end
        return p;
    endfunction

    // One frame: tick (optionally with death) then enough idle cycles for rgb_out to settle.
    task automatic tick(input logic with_death);
        frame_tick = 1'b1;
        death      = with_death;
        step();
        frame_tick = 1'b0;
        death      = 1'b0;
        step();
        step();
        step();
    endtask

    initial begin
        logic [NL*CW-1:0] pal;
        logic [NL*CW-1:0] spec_rgb;
        logic [NL*CW-1:0] key_rgb;
        logic [1:0]       exp_st;
        logic [CW-1:0]    exp_px;
        int               j;

        pal      = palette();
        spec_rgb = pal;
        spec_rgb[1*CW +: CW] = 12'hF00;
        spec_rgb[5*CW +: CW] = 12'h00F;
        key_rgb  = pal;
        key_rgb[0*CW +: CW] = 12'h000;
        key_rgb[3*CW +: CW] = 12'hABC;

        vecs[0] = '{12'h000, pal, 1'b1, 2'b10, 12'h69C, 2'b10};
        vecs[1] = '{12'b0000_0010_0010, spec_rgb, 1'b1, 2'b01, 12'hF00, 2'b01};
        vecs[2] = '{12'b0000_0010_0000, spec_rgb, 1'b1, 2'b11, 12'h00F, 2'b11};
        vecs[3] = '{12'hFFF, pal, 1'b0, 2'b00, 12'h000, 2'b00};
        vecs[4] = '{12'hFFF, pal, 1'b1, 2'b10, 12'h1A0, 2'b10};
        vecs[5] = '{12'h800, pal, 1'b1, 2'b01, 12'hCAB, 2'b01};
        vecs[6] = '{12'h300, pal, 1'b1, 2'b11, 12'h9A8, 2'b11};
        vecs[7] = '{12'b1010_0000_1000, pal, 1'b1, 2'b00, 12'h4A3, 2'b00};
        vecs[8] = '{12'h000, pal, 1'b0, 2'b11, 12'h000, 2'b11};
`ifdef COLOR_KEY_EN
        vecs[9] = '{12'b0000_0000_1001, key_rgb, 1'b1, 2'b10, 12'hABC, 2'b10};
`else
        vecs[9] = '{12'b0000_0000_1001, key_rgb, 1'b1, 2'b10, 12'h000, 2'b10};
`endif

        reset      = 1'b1;
        layer_en   = '0;
        layer_rgb  = pal;
        bright     = 1'b1;
        sync_in    = 2'b00;
        frame_tick = 1'b0;
        death      = 1'b0;
        game_over  = 1'b0;
        step();
        step();
        step();
        check("reset_rgb", 32'(rgb_out), 32'h000);
        check("reset_sync", 32'(sync_out), 32'h3);
        check("reset_state", 32'(mix_state), 32'h0);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            layer_en  = vecs[i].en;
            layer_rgb = vecs[i].rgb;
            bright    = vecs[i].bright;
            sync_in   = vecs[i].sync;
            step();
            step();
            check($sformatf("vec%0d_rgb", i), 32'(rgb_out), 32'(vecs[i].exp_rgb));
            check($sformatf("vec%0d_sync", i), 32'(sync_out), 32'(vecs[i].exp_sync));
        end

        // Back-to-back pixels: each appears exactly two edges after it is driven.
        layer_rgb = pal;
        bright    = 1'b1;
        layer_en  = 12'h001;
        sync_in   = 2'b01;
        step();
        layer_en  = 12'h000;
        sync_in   = 2'b10;
        step();
        check("pipe_a_rgb", 32'(rgb_out), 32'h1A0);
        check("pipe_a_sync", 32'(sync_out), 32'h1);
        step();
        check("pipe_b_rgb", 32'(rgb_out), 32'h69C);
        check("pipe_b_sync", 32'(sync_out), 32'h2);

        // Death flash: 60 frames, 8 on / 8 off.
        layer_en = 12'h004;
        sync_in  = 2'b11;
        tick(1'b0);
        check("play_tick_state", 32'(mix_state), 32'h0);
        check("play_tick_rgb", 32'(rgb_out), 32'h3A2);
        death = 1'b1;
        step();
        death = 1'b0;
        step();
        step();
        check("flash_enter_state", 32'(mix_state), 32'h1);
        check("flash_enter_rgb", 32'(rgb_out), 32'h0F0);
        for (int k = 1; k <= 60; k++) begin
            exp_st = (k < 60) ? 2'd1 : 2'd0;
            exp_px = ((k < 60) && ((k % 16) < 8)) ? 12'h0F0 : 12'h3A2;
            tick(1'b0);
            check($sformatf("flash1_k%0d_state", k), 32'(mix_state), 32'(exp_st));
            check($sformatf("flash1_k%0d_rgb", k), 32'(rgb_out), 32'(exp_px));
        end

        // Second death on the same cycle as tick 30 restarts the count: flash ends at tick 90.
        death = 1'b1;
        step();
        death = 1'b0;
        step();
        step();
        for (int k = 1; k <= 90; k++) begin
            j      = (k >= 30) ? k - 30 : k;
            exp_st = (k < 90) ? 2'd1 : 2'd0;
            exp_px = ((k < 90) && ((j % 16) < 8)) ? 12'h0F0 : 12'h3A2;
            tick(k == 30);
            check($sformatf("flash2_k%0d_state", k), 32'(mix_state), 32'(exp_st));
            check($sformatf("flash2_k%0d_rgb", k), 32'(rgb_out), 32'(exp_px));
        end

        // game_over during a flash jumps to OVER.
        death = 1'b1;
        step();
        death = 1'b0;
        tick(1'b0);
        tick(1'b0);
        game_over = 1'b1;
        step();
        game_over = 1'b0;
        step();
        step();
        check("flash_to_over_state", 32'(mix_state), 32'h2);
        check("flash_to_over_rgb", 32'(rgb_out), 32'h0F0);

        // Reset, then death and game_over together: game_over wins and is sticky.
        reset = 1'b1;
        step();
        check("reset2_state", 32'(mix_state), 32'h0);
        check("reset2_rgb", 32'(rgb_out), 32'h000);
        reset = 1'b0;
        step();
        check("refill_rgb", 32'(rgb_out), 32'h000);
        step();
        check("refilled_rgb", 32'(rgb_out), 32'h3A2);
        death     = 1'b1;
        game_over = 1'b1;
        step();
        death     = 1'b0;
        game_over = 1'b0;
        step();
        step();
        check("over_state", 32'(mix_state), 32'h2);
        check("over_rgb", 32'(rgb_out), 32'h0F0);
        for (int k = 1; k <= 200; k++) begin
            tick(k == 100);
            if ((k % 50) == 0) begin
                check($sformatf("over_k%0d_state", k), 32'(mix_state), 32'h2);
                check($sformatf("over_k%0d_rgb", k), 32'(rgb_out), 32'h0F0);
            end
        end
        bright = 1'b0;
        step();
        step();
        check("over_dark_rgb", 32'(rgb_out), 32'h000);
        bright = 1'b1;
        reset  = 1'b1;
        step();
        reset = 1'b0;
        step();
        step();
        check("over_reset_state", 32'(mix_state), 32'h0);
        check("over_reset_rgb", 32'(rgb_out), 32'h3A2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
